// File: rtl/led_shifter.sv
// ============================================================================
//  Module   : led_shifter
//  Purpose  : Serialises a c_channels x c_bpc frame buffer MSB-first into
//             daisy-chained LED driver boards, then pulses LATCH and o_done.
//  Options  : LED_SHIFTER_BLANK_EN adds o_blank around the latch window.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module led_shifter #(
  parameter int c_ledboards    = 30,
  parameter int c_bpc          = 12,
  parameter int c_channels     = c_ledboards * 32,
  parameter int c_addr_w       = $clog2(c_channels),
  parameter int c_clkdiv       = 4,
  parameter int c_latch_cycles = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [c_bpc-1:0]    i_data,
  output logic [c_addr_w-1:0] o_addr,
  output logic                o_sclk,
  output logic                o_sdata,
  output logic                o_latch,
  output logic                o_busy,
`ifdef LED_SHIFTER_BLANK_EN
  output logic                o_blank,
`endif
  output logic                o_done
);

  localparam int c_div_w = $clog2(c_clkdiv + 1);
  localparam int c_bit_w = $clog2(c_bpc + 1);
  localparam int c_lat_w = $clog2(c_latch_cycles + 1);

  localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(c_clkdiv - 1);
  localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(c_bpc - 1);
  localparam logic [c_lat_w-1:0]  c_lat_last  = c_lat_w'(c_latch_cycles - 1);
  localparam logic [c_addr_w-1:0] c_addr_last = c_addr_w'(c_channels - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_LATCH = 3'd4,
    S_TAIL  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t              r_state, w_state;
  logic [c_addr_w-1:0] r_addr,  w_addr;
  logic [c_bpc-1:0]    r_sr,    w_sr;
  logic [c_div_w-1:0]  r_div,   w_div;
  logic [c_bit_w-1:0]  r_bit,   w_bit;
  logic [c_lat_w-1:0]  r_lcnt,  w_lcnt;
  logic                r_sclk,  w_sclk;
  logic                r_sdata, w_sdata;
  logic                r_latch, w_latch;
  logic                r_busy,  w_busy;
  logic                r_done,  w_done;
  logic                r_blank, w_blank;
  logic [c_bpc-1:0]    w_sr_shl;

  assign w_sr_shl = r_sr << 1;

  always_comb begin
    w_state = r_state;
    w_addr  = r_addr;
    w_sr    = r_sr;
    w_div   = r_div;
    w_bit   = r_bit;
    w_lcnt  = r_lcnt;
    w_sclk  = r_sclk;
    w_sdata = r_sdata;
    w_latch = r_latch;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_blank = r_blank;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_addr  = c_addr_last;
          w_busy  = 1'b1;
          w_state = S_FETCH;
        end
      end
      S_FETCH: w_state = S_LOAD;
      S_LOAD: begin
        w_sr    = i_data;
        w_sdata = i_data[c_bpc-1];
        w_div   = '0;
        w_bit   = '0;
        w_state = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_div == c_div_last) begin
          w_div = '0;
          if (!r_sclk) begin
            w_sclk = 1'b1;
          end else begin
            // Falling SCLK edge: present the next bit, or finish the word.
            w_sclk = 1'b0;
            if (r_bit == c_bit_last) begin
              w_bit = '0;
              if (r_addr == '0) begin
                w_state = S_LATCH;
                w_blank = 1'b1;
              end else begin
                w_addr  = r_addr - c_addr_w'(1);
                w_state = S_FETCH;
              end
            end else begin
              w_bit   = r_bit + c_bit_w'(1);
              w_sr    = w_sr_shl;
              w_sdata = w_sr_shl[c_bpc-1];
            end
          end
        end else begin
          w_div = r_div + c_div_w'(1);
        end
      end
      S_LATCH: begin
        if (!r_latch) begin
          if (r_div == c_div_last) begin
            w_div   = '0;
            w_latch = 1'b1;
          end else begin
            w_div = r_div + c_div_w'(1);
          end
        end else if (r_lcnt == c_lat_last) begin
          w_lcnt  = '0;
          w_latch = 1'b0;
`ifdef LED_SHIFTER_BLANK_EN
          w_state = S_TAIL;
`else
          w_state = S_DONE;
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_sdata = 1'b0;
`endif
        end else begin
          w_lcnt = r_lcnt + c_lat_w'(1);
        end
      end
`ifdef LED_SHIFTER_BLANK_EN
      S_TAIL: begin
        w_blank = 1'b0;
        w_state = S_DONE;
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_sdata = 1'b0;
      end
`endif
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_sr    <= '0;
      r_div   <= '0;
      r_bit   <= '0;
      r_lcnt  <= '0;
      r_sclk  <= 1'b0;
      r_sdata <= 1'b0;
      r_latch <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_blank <= 1'b0;
    end else begin
      r_state <= w_state;
      r_addr  <= w_addr;
      r_sr    <= w_sr;
      r_div   <= w_div;
      r_bit   <= w_bit;
      r_lcnt  <= w_lcnt;
      r_sclk  <= w_sclk;
      r_sdata <= w_sdata;
      r_latch <= w_latch;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_blank <= w_blank;
    end
  end

  assign o_addr  = r_addr;
  assign o_sclk  = r_sclk;
  assign o_sdata = r_sdata;
  assign o_latch = r_latch;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
`ifdef LED_SHIFTER_BLANK_EN
  assign o_blank = r_blank;
`else
  logic w_blank_unused;
  assign w_blank_unused = r_blank ^ w_blank;
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_shifter.sv
// ============================================================================
//  Module   : tb_led_shifter
//  Purpose  : Frame-level model check of led_shifter (div 1 and div 3 instances).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_led_shifter;
  localparam int C = 32;
  localparam int B = 12;
  localparam int L = 4;
`ifdef LED_SHIFTER_BLANK_EN
  localparam int BLK = 1;
`else
  localparam int BLK = 0;
`endif

  typedef struct packed {
    logic [4:0] addr;
    logic sclk;
    logic sdata;
    logic latch;
    logic busy;
    logic done;
    logic blank;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start1 = 1'b0, start3 = 1'b0;
  logic [11:0] data1 = '0, data3 = '0;
  logic [4:0] addr1, addr3;
  logic sclk1, sdata1, latch1, busy1, done1, blank1;
  logic sclk3, sdata3, latch3, busy3, done3, blank3;
  logic [11:0] ram1 [32];
  logic [11:0] ram3 [32];

  led_shifter #(.c_ledboards(1), .c_bpc(12), .c_clkdiv(1), .c_latch_cycles(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_data(data1), .o_addr(addr1),
    .o_sclk(sclk1), .o_sdata(sdata1), .o_latch(latch1), .o_busy(busy1),
`ifdef LED_SHIFTER_BLANK_EN
    .o_blank(blank1),
`endif
    .o_done(done1));

  led_shifter #(.c_ledboards(1), .c_bpc(12), .c_clkdiv(3), .c_latch_cycles(4)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start3), .i_data(data3), .o_addr(addr3),
    .o_sclk(sclk3), .o_sdata(sdata3), .o_latch(latch3), .o_busy(busy3),
`ifdef LED_SHIFTER_BLANK_EN
    .o_blank(blank3),
`endif
    .o_done(done3));

`ifndef LED_SHIFTER_BLANK_EN
  assign blank1 = 1'b0;
  assign blank3 = 1'b0;
`endif

  // 1-cycle-latency frame buffers
  always @(posedge clk) begin
    data1 <= ram1[addr1];
    data3 <= ram3[addr3];
  end

  int vectors = 0, miscompares = 0, cyc = 0;
  int ft [2] = '{0, 0};
  int t_start [2] = '{0, 0};
  int t_done [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int last_done [2] = '{0, 0};
  int interval [2] = '{0, 0};
  int rises [2] = '{0, 0};
  int ones [2] = '{0, 0};
  int hirun [2] = '{0, 0};
  int hibad [2] = '{0, 0};
  logic [11:0] fb [2];
  logic prev_sd [2];
  logic prev_sc [2];

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int done_at(input int i);
    return C * (2 + 2 * div_of(i) * B) + div_of(i) + L + 1 + BLK;
  endfunction

  function automatic logic [11:0] word(input int i, input int a);
    return (i == 0) ? ram1[a] : ram3[a];
  endfunction

  // Expected outputs at frame cycle ft (1 = first cycle after start acceptance).
  function automatic obs_t model(input int i, input int f);
    obs_t e;
    int d, w, k, o, s, j;
    logic [11:0] v;
    e = '0;
    if (f == 0) return e;
    d = div_of(i);
    w = 2 + 2 * d * B;
    e.busy = 1'b1;
    if (f <= C * w) begin
      k = (f - 1) / w;
      o = (f - 1) % w;
      e.addr = 5'(C - 1 - k);
      if (o < 2) begin
        if (k > 0) begin
          v = word(i, C - k);
          e.sdata = v[0];
        end
      end else begin
        s = o - 2;
        j = s / (2 * d);
        e.sclk = ((s % (2 * d)) >= d);
        v = word(i, C - 1 - k);
        e.sdata = v[B - 1 - j];
      end
    end else if (f == done_at(i)) begin
      e.busy = 1'b0;
      e.done = 1'b1;
    end else begin
      o = f - C * w;
      v = word(i, 0);
      e.sdata = v[0];
      e.latch = (o > d && o <= d + L);
      e.blank = (BLK == 1);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) ft[i] = 0;
      else if (ft[i] != 0) begin
        ft[i]++;
        if (ft[i] > done_at(i)) ft[i] = 0;
      end else if ((i == 0) ? start1 : start3) begin
        ft[i] = 1;
        t_start[i] = cyc;
      end
    end
  end

  obs_t a, e;
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        a = (i == 0) ? {addr1, sclk1, sdata1, latch1, busy1, done1, blank1}
                     : {addr3, sclk3, sdata3, latch3, busy3, done3, blank3};
        e = model(i, ft[i]);
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle_model div%0d cyc %0d: got %h expected %h", div_of(i), cyc, a, e);
        end
        vectors++;
        if (a.sclk && (a.sdata !== prev_sd[i])) begin
          miscompares++;
          $display("FAIL sdata_stable div%0d cyc %0d: sdata %b changed while sclk %b, expected no change", div_of(i), cyc, a.sdata, a.sclk);
        end
        if (a.sclk && !prev_sc[i]) begin
          rises[i]++;
          ones[i] += int'(a.sdata);
          if (rises[i] <= 12) fb[i] = {fb[i][10:0], a.sdata};
        end
        if (a.sclk) hirun[i]++;
        else begin
          if (prev_sc[i] && hirun[i] != div_of(i)) hibad[i]++;
          hirun[i] = 0;
        end
        if (a.done) begin
          done_cnt[i]++;
          t_done[i] = cyc - t_start[i] + 1;
          interval[i] = cyc - last_done[i];
          last_done[i] = cyc;
        end
        prev_sd[i] = a.sdata;
        prev_sc[i] = a.sclk;
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr(input int i);
    rises[i] = 0; ones[i] = 0; fb[i] = '0; hibad[i] = 0; hirun[i] = 0;
  endtask

  task automatic pulse(input int i);
    if (i == 0) start1 = 1'b1; else start3 = 1'b1;
    step(1);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int c0 = done_cnt[i];
    int n = 0;
    while (done_cnt[i] == c0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt[i] == c0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout div%0d: no o_done within %0d cycles, expected one", div_of(i), budget);
    end
  endtask

  initial begin
    int dc;
    for (int k = 0; k < 32; k++) begin
      ram1[k] = 12'((k * 'h101) & 'hFFF);
      ram3[k] = 12'((k * 'h101) & 'hFFF);
    end
    prev_sd = '{1'b0, 1'b0};
    prev_sc = '{1'b0, 1'b0};
    fb = '{12'h0, 12'h0};
    step(3);
    rst = 1'b0;
    check("reset_busy", int'(busy1), 0);
    check("reset_addr", int'(addr1), 0);
    check("reset_done", int'(done1), 0);

    // Ramp pattern, single frame
    clr(0);
    pulse(0);
    wait_done(0, 3000);
    check("t1_latency", t_done[0], 838 + BLK);
    check("t1_sclk_rises", rises[0], 384);
    check("t1_first_word", int'(fb[0]), 'hF1F);
    step(3);

    // All ones, then all zeros
    for (int k = 0; k < 32; k++) ram1[k] = 12'hFFF;
    clr(0);
    pulse(0);
    wait_done(0, 3000);
    check("t2_ones_all_set", ones[0], 384);
    step(2);
    for (int k = 0; k < 32; k++) ram1[k] = 12'h000;
    clr(0);
    pulse(0);
    wait_done(0, 3000);
    check("t2_ones_all_clear", ones[0], 0);
    check("t2_sclk_rises", rises[0], 384);
    step(2);

    // i_start held high: back-to-back frames
    for (int k = 0; k < 32; k++) ram1[k] = 12'((k * 37 + 'h300) & 'hFFF);
    start1 = 1'b1;
    wait_done(0, 3000);
    wait_done(0, 3000);
    check("t3_period_2", interval[0], 839 + BLK);
    wait_done(0, 3000);
    check("t3_period_3", interval[0], 839 + BLK);
    start1 = 1'b0;
    step(5);
    check("t3_idle_after_release", int'(busy1), 0);

    // Mid-frame reset aborts without latch/done
    clr(0);
    pulse(0);
    step(398);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t4_busy_after_rst", int'(busy1), 0);
    check("t4_sclk_after_rst", int'(sclk1), 0);
    check("t4_addr_after_rst", int'(addr1), 0);
    dc = done_cnt[0];
    step(900);
    check("t4_no_done_after_abort", done_cnt[0] - dc, 0);
    clr(0);
    pulse(0);
    wait_done(0, 3000);
    check("t4_latency", t_done[0], 838 + BLK);
    check("t4_sclk_rises", rises[0], 384);
    step(2);

    // Clock divider of 3
    clr(1);
    pulse(1);
    wait_done(1, 5000);
    check("t5_latency", t_done[1], 2376 + BLK);
    check("t5_high_phase_width_errors", hibad[1], 0);
    check("t5_sclk_rises", rises[1], 384);
    check("t5_first_word", int'(fb[1]), 'hF1F);
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
